// File: rtl/button_event_unit.sv
// Edge detector with sticky press/release pending and overrun flags plus a registered irq.
// Optional per-channel auto-repeat of held presses is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_event_unit #(
    parameter int unsigned        WIDTH         = 1,
    parameter int unsigned        CNT_W         = 24,
    parameter logic [CNT_W-1:0]   REPEAT_DELAY  = CNT_W'(5000000),
    parameter logic [CNT_W-1:0]   REPEAT_PERIOD = CNT_W'(1000000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] debounced_in,
    input  logic [WIDTH-1:0] press_clr,
    input  logic [WIDTH-1:0] release_clr,
    input  logic [WIDTH-1:0] irq_en,
    output logic [WIDTH-1:0] press_pending,
    output logic [WIDTH-1:0] release_pending,
    output logic [WIDTH-1:0] press_overrun,
    output logic [WIDTH-1:0] release_overrun,
    output logic [WIDTH-1:0] level_out,
    output logic             irq
);

    logic             primed_q, primed_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] ppend_q, ppend_d;
    logic [WIDTH-1:0] rpend_q, rpend_d;
    logic [WIDTH-1:0] povr_q, povr_d;
    logic [WIDTH-1:0] rovr_q, rovr_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] press_edge;
    logic [WIDTH-1:0] release_edge;
    logic [WIDTH-1:0] press_evt;

    // Edges are suppressed until level_q holds a real sample, so a button held through reset is silent.
    always_comb begin
        press_edge   = primed_q ? (debounced_in & ~level_q) : '0;
        release_edge = primed_q ? (~debounced_in & level_q) : '0;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = REPEAT_DELAY - 1'b1;
    localparam logic [CNT_W-1:0] PERIOD_LOAD = REPEAT_PERIOD - 1'b1;

    rpt_state_e       state_q [WIDTH];
    rpt_state_e       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] repeat_fire;

    // Outside IDLE the button is known to be held, so "no release edge" means "still pressed".
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            repeat_fire[i] = 1'b0;
            case (state_q[i])
                RPT_IDLE: begin
                    if (press_edge[i]) begin
                        state_d[i] = RPT_DELAY;
                        cnt_d[i]   = DELAY_LOAD;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (release_edge[i]) begin
                        state_d[i] = RPT_IDLE;
                    end else if (cnt_q[i] == '0) begin
                        repeat_fire[i] = 1'b1;
                        cnt_d[i]       = PERIOD_LOAD;
                        state_d[i]     = RPT_REPEAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                default: state_d[i] = RPT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= RPT_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign press_evt = press_edge | repeat_fire;
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign press_evt  = press_edge;
`endif

    // An event in the same cycle as its clear strobe keeps pending set and drops overrun.
    always_comb begin
        primed_d = 1'b1;
        level_d  = debounced_in;
        ppend_d  = press_evt | (ppend_q & ~press_clr);
        povr_d   = (povr_q & ~press_clr) | (press_evt & ppend_q & ~press_clr);
        rpend_d  = release_edge | (rpend_q & ~release_clr);
        rovr_d   = (rovr_q & ~release_clr) | (release_edge & rpend_q & ~release_clr);
        irq_d    = |((ppend_d | rpend_d) & irq_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed_q <= 1'b0;
            level_q  <= '0;
            ppend_q  <= '0;
            povr_q   <= '0;
            rpend_q  <= '0;
            rovr_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            primed_q <= primed_d;
            level_q  <= level_d;
            ppend_q  <= ppend_d;
            povr_q   <= povr_d;
            rpend_q  <= rpend_d;
            rovr_q   <= rovr_d;
            irq_q    <= irq_d;
        end
    end

    assign press_pending   = ppend_q;
    assign release_pending = rpend_q;
    assign press_overrun   = povr_q;
    assign release_overrun = rovr_q;
    assign level_out       = level_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_button_event_unit.sv
// Directed + random bench for button_event_unit (WIDTH=4) with a queued expected-output scoreboard.
module tb_button_event_unit;

    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] debounced_in = '0;
    logic [3:0] press_clr = '0;
    logic [3:0] release_clr = '0;
    logic [3:0] irq_en = '0;
    logic [3:0] press_pending, release_pending, press_overrun, release_overrun, level_out;
    logic       irq;

    button_event_unit #(
        .WIDTH(4),
        .CNT_W(24),
        .REPEAT_DELAY(24'd20),
        .REPEAT_PERIOD(24'd8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .debounced_in(debounced_in),
        .press_clr(press_clr),
        .release_clr(release_clr),
        .irq_en(irq_en),
        .press_pending(press_pending),
        .release_pending(release_pending),
        .press_overrun(press_overrun),
        .release_overrun(release_overrun),
        .level_out(level_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pp, rp, po, ro, lv;
        logic       irq;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   sn = 0;

    logic       m_primed;
    logic [3:0] m_lv, m_pp, m_rp, m_po, m_ro;
    logic       m_irq;
`ifdef BUTTON_AUTOREPEAT_EN
    int   m_t   [4];
    logic m_trk [4];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s step %0d: got %h expected %h", tag, sn, obs, exp);
    endtask

    function automatic void model_reset();
        m_primed = 1'b0;
        m_lv = '0; m_pp = '0; m_rp = '0; m_po = '0; m_ro = '0; m_irq = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        for (int i = 0; i < 4; i++) begin
            m_t[i] = 0;
            m_trk[i] = 1'b0;
        end
`endif
    endfunction

    function automatic void model_next(input logic [3:0] din, pclr, rclr, en);
        for (int i = 0; i < 4; i++) begin
            logic pe, re;
            pe = m_primed && din[i] && !m_lv[i];
            re = m_primed && !din[i] && m_lv[i];
`ifdef BUTTON_AUTOREPEAT_EN
            if (m_trk[i]) begin
                if (re) m_trk[i] = 1'b0;
                else begin
                    m_t[i]++;
                    if (m_t[i] == RD || (m_t[i] > RD && (m_t[i] - RD) % RP == 0)) pe = 1'b1;
                end
            end else if (pe) begin
                m_trk[i] = 1'b1;
                m_t[i] = 0;
            end
`endif
            if (pe) begin
                m_po[i] = pclr[i] ? 1'b0 : (m_po[i] | m_pp[i]);
                m_pp[i] = 1'b1;
            end else if (pclr[i]) begin
                m_pp[i] = 1'b0;
                m_po[i] = 1'b0;
            end
            if (re) begin
                m_ro[i] = rclr[i] ? 1'b0 : (m_ro[i] | m_rp[i]);
                m_rp[i] = 1'b1;
            end else if (rclr[i]) begin
                m_rp[i] = 1'b0;
                m_ro[i] = 1'b0;
            end
        end
        m_lv = din;
        m_primed = 1'b1;
        m_irq = |((m_pp | m_rp) & en);
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.pp = m_pp; e.rp = m_rp; e.po = m_po; e.ro = m_ro; e.lv = m_lv; e.irq = m_irq;
        return e;
    endfunction

    task automatic compare_next();
        exp_t e;
        e = sb_q.pop_front();
        chk("press_pending", 32'(press_pending), 32'(e.pp));
        chk("release_pending", 32'(release_pending), 32'(e.rp));
        chk("press_overrun", 32'(press_overrun), 32'(e.po));
        chk("release_overrun", 32'(release_overrun), 32'(e.ro));
        chk("level_out", 32'(level_out), 32'(e.lv));
        chk("irq", 32'(irq), 32'(e.irq));
    endtask

    // Drive one cycle of inputs, queue the model's prediction, check just after the clock edge.
    task automatic step(input logic [3:0] din, pclr, rclr, en);
        debounced_in = din;
        press_clr    = pclr;
        release_clr  = rclr;
        irq_en       = en;
        model_next(din, pclr, rclr, en);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        sn++;
        compare_next();
        press_clr   = '0;
        release_clr = '0;
    endtask

    task automatic do_reset(input logic [3:0] din);
        debounced_in = din;
        press_clr    = '0;
        release_clr  = '0;
        reset        = 1'b1;
        model_reset();
        sb_q.push_back(model_exp());
        #2;
        compare_next();
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(model_exp());
        compare_next();
        reset = 1'b0;
    endtask

    initial begin
        // button held through reset: priming must not report a press
        do_reset(4'b0001);
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, '0, '0, 4'hF);
            chk("held_no_press", 32'(press_pending), 32'd0);
            chk("held_no_irq", 32'(irq), 32'd0);
        end

        step(4'b0000, '0, '0, 4'hF);
        chk("rel_seen", 32'(release_pending), 32'h1);
        step(4'b0000, '0, 4'b0001, 4'hF);
        step(4'b0100, '0, '0, 4'hF);
        chk("press_b2", 32'(press_pending), 32'h4);
        chk("press_b2_irq", 32'(irq), 32'h1);
        step(4'b0100, 4'b0100, '0, 4'hF);
        chk("clr_b2", 32'(press_pending), 32'h0);
        chk("clr_b2_irq", 32'(irq), 32'h0);

        // double press/release on bit 0 without clearing
        step(4'b0101, '0, '0, 4'hF);
        step(4'b0100, '0, '0, 4'hF);
        step(4'b0101, '0, '0, 4'hF);
        step(4'b0100, '0, '0, 4'hF);
        chk("ovr_pp", 32'(press_pending), 32'h1);
        chk("ovr_po", 32'(press_overrun), 32'h1);
        chk("ovr_ro", 32'(release_overrun), 32'h1);
        step(4'b0100, '0, 4'b0001, 4'hF);
        chk("rclr_rp", 32'(release_pending), 32'h0);
        chk("rclr_ro", 32'(release_overrun), 32'h0);
        chk("rclr_keeps_po", 32'(press_overrun), 32'h1);
        step(4'b0100, 4'b0001, '0, 4'hF);

        // press edge coincident with press_clr while already pending
        step(4'b0110, '0, '0, 4'hF);
        step(4'b0100, '0, '0, 4'hF);
        step(4'b0110, 4'b0010, 4'b0010, 4'hF);
        chk("setwin_pp", 32'(press_pending), 32'h2);
        chk("setwin_po", 32'(press_overrun), 32'h0);
        step(4'b0000, 4'b0010, '0, 4'hF);
        step(4'b0000, '0, 4'b0110, 4'hF);

        // interrupt enable gating
        step(4'b0001, '0, '0, 4'h0);
        chk("masked_irq", 32'(irq), 32'h0);
        step(4'b0001, '0, '0, 4'b0001);
        chk("unmasked_irq", 32'(irq), 32'h1);

        // strobes held high across edges, then clearing bits that are not set
        step(4'b0101, 4'hF, 4'hF, 4'hF);
        step(4'b0001, 4'hF, 4'hF, 4'hF);
        step(4'b0001, 4'hF, 4'hF, 4'hF);
        chk("held_clr_pp", 32'(press_pending), 32'h0);
        step(4'b0001, 4'hF, 4'hF, 4'hF);

        // asynchronous reset mid-operation, then re-prime with buttons held
        step(4'b0011, '0, '0, 4'hF);
        do_reset(4'b0011);
        for (int k = 0; k < 10; k++) step(4'b0011, '0, '0, 4'hF);
        step(4'b0001, '0, '0, 4'hF);
        chk("reprime_rel", 32'(release_pending), 32'h2);

`ifdef BUTTON_AUTOREPEAT_EN
        begin
            int   ev[$];
            int   exp_ev[5];
            logic clr0;
            exp_ev = '{1, 21, 29, 37, 45};
            do_reset(4'b0000);
            step(4'b0000, '0, '0, 4'hF);
            clr0 = 1'b0;
            for (int j = 0; j <= 52; j++) begin
                step((j < 52) ? 4'b0001 : 4'b0000, {3'b000, clr0}, '0, 4'hF);
                if (press_pending[0]) ev.push_back(j + 1);
                clr0 = press_pending[0];
            end
            for (int j = 0; j < 10; j++) begin
                step(4'b0000, {3'b000, clr0}, 4'hF, 4'hF);
                if (press_pending[0] && !clr0) ev.push_back(53 + j);
                clr0 = press_pending[0];
            end
            chk("ar_count", 32'(ev.size()), 32'd5);
            for (int k = 0; k < 5 && k < ev.size(); k++) chk("ar_cycle", 32'(ev[k]), 32'(exp_ev[k]));
        end
`endif

        for (int k = 0; k < 200; k++) begin
            logic [3:0] d, pc, rc, en;
            d  = 4'($urandom);
            pc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            en = 4'($urandom);
            step(d, pc, rc, en);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
